// File: rtl/usb_tx_bank_scheduler.sv
// usb_tx_bank_scheduler: streams filled buffer banks to a USB FIFO
// in strict cyclic bank order, one byte per read/write handshake.
module usb_tx_bank_scheduler #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int BANKS     = 2,
  parameter int BLOCK_LEN = 126,
  parameter int RD_LAT    = 1,
  parameter int WR_PULSE  = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ena_i,
  input  logic [BANKS-1:0]  buff_ready_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] raddr_o,
  input  logic [DATA_W-1:0] q_i,
  input  logic              txe_i,
  output logic              wr_o,
  output logic [DATA_W-1:0] d_o,
  output logic [BANKS-1:0]  bank_done_o,
  output logic              busy_o,
  output logic              overrun_o
);

  localparam int CUR_W = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam logic [3:0] RDW_LAST = 4'(RD_LAT - 2);
  localparam logic [3:0] WR_LAST  = 4'(WR_PULSE - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(BLOCK_LEN - 1);
  localparam logic [CUR_W-1:0]  CUR_LAST = CUR_W'(BANKS - 1);

  typedef enum logic [2:0] {
    S_WAIT, S_CHECK, S_READ, S_RDWAIT,
    S_LOAD, S_WRITE, S_HOLD, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CUR_W-1:0]  cur_q, cur_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [BANKS-1:0]  pend_q, pend_d;
  logic              ovr_q, ovr_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [DATA_W-1:0] d_q, d_d;

  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] addr;
  logic              last;
  logic [BANKS-1:0]  cur_oh;
  logic [BANKS-1:0]  done_oh;

  assign base    = ADDR_W'(int'(cur_q) * BLOCK_LEN);
  assign addr    = base + idx_q;
  assign last    = (idx_q == IDX_LAST);
  assign cur_oh  = BANKS'(1) << cur_q;
  assign done_oh = (state_q == S_DONE) ? cur_oh : '0;

  // state and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_WAIT;
      cur_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= '0;
      ovr_q   <= 1'b0;
      raddr_q <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      raddr_q <= raddr_d;
      d_q     <= d_d;
    end
  end

  // next-state logic of the per-byte handshake
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_WAIT:
        if (pend_q[cur_q] && ena_i) state_d = S_CHECK;
      S_CHECK:
        if (!txe_i && ena_i) state_d = S_READ;
      S_READ:
        state_d = (RD_LAT > 1) ? S_RDWAIT : S_LOAD;
      S_RDWAIT:
        if (cnt_q == RDW_LAST) state_d = S_LOAD;
      S_LOAD:
        state_d = S_WRITE;
      S_WRITE:
        if (cnt_q == WR_LAST) state_d = S_HOLD;
      S_HOLD:
        state_d = last ? S_DONE : S_CHECK;
      S_DONE:
        state_d = S_WAIT;
      default:
        state_d = S_WAIT;
    endcase
  end

  // counters, pending bookkeeping and held read/write values
  always_comb begin
    cnt_d   = (state_d != state_q) ? 4'd0 : cnt_q + 4'd1;
    idx_d   = idx_q;
    cur_d   = cur_q;
    raddr_d = raddr_q;
    d_d     = d_q;
    if (state_q == S_WAIT) idx_d = '0;
    if (state_q == S_HOLD && !last) idx_d = idx_q + 1'b1;
    if (state_q == S_READ) raddr_d = addr;
    if (state_q == S_LOAD) d_d = q_i;
    if (state_q == S_DONE)
      cur_d = (cur_q == CUR_LAST) ? '0 : cur_q + 1'b1;
    // a fill arriving on the releasing cycle counts as a fresh fill
    pend_d = (pend_q & ~done_oh) | buff_ready_i;
    ovr_d  = ovr_q | (|(buff_ready_i & pend_q & ~done_oh));
  end

  // outputs decoded from state
  always_comb begin
    rd_en_o     = (state_q == S_READ);
    raddr_o     = (state_q == S_READ) ? addr : raddr_q;
    wr_o        = (state_q == S_WRITE);
    d_o         = d_q;
    bank_done_o = done_oh;
    busy_o      = (state_q != S_WAIT);
    overrun_o   = ovr_q;
  end

endmodule
